address_write_stager: RTL and testbench
=======================================

ADDRESS_WRITE_STAGER -- requirements
Module: address_write_stager

Interface
REQ-001 Parameter WRITE_WORD_WIDTH, default 36, width of the staged write data.
REQ-002 Parameter WRITE_ADDR_WIDTH, default 12, width of the staged write address.
REQ-003 Parameter DEPTH, default 2, number of retiming stages, legal range 1..8.
REQ-004 Parameter THREAD_COUNT, default 8, number of round-robin threads, at least 2.
REQ-005 Parameter THREAD_COUNT_WIDTH, default 3, equal to ceil(log2(THREAD_COUNT)).
REQ-006 Parameter IDLE_ADDR, default 0, address driven when no write is valid; it SHALL lie outside all PO/DO mapped ranges.
REQ-007 clock  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 in_write_addr  in  WRITE_ADDR_WIDTH  write address of the previous instruction.
REQ-010 in_write_data  in  WRITE_WORD_WIDTH  write data of the previous instruction.
REQ-011 IO_Ready_previous  in  1  previous instruction's I/O was ready.
REQ-012 Cancel_previous  in  1  previous instruction was cancelled or annulled.
REQ-013 check_addr  in  WRITE_ADDR_WIDTH  address probed for in-flight hazards.
REQ-014 current_thread  out  THREAD_COUNT_WIDTH  round-robin thread number.
REQ-015 out_write_addr  out  WRITE_ADDR_WIDTH  staged address, feeding the address-module write port.
REQ-016 out_write_data  out  WRITE_WORD_WIDTH  staged data.
REQ-017 out_write_valid  out  1  staged write is valid.
REQ-018 out_write_thread  out  THREAD_COUNT_WIDTH  thread that issued the staged write.
REQ-019 hazard  out  1  in-flight write matches check_addr for current_thread.

Function
REQ-020 current_thread SHALL increment by 1 every cycle and wrap from THREAD_COUNT-1 to 0.
REQ-021 Stage 1 SHALL capture the entry write with valid = IO_Ready_previous AND NOT Cancel_previous, tagged with thread = current_thread.
REQ-022 An invalid entry SHALL be stored with addr = IDLE_ADDR and data = 0, regardless of the inputs.
REQ-023 Each stage k>1 SHALL copy stage k-1 every cycle, giving a fixed latency of DEPTH cycles from entry to the out_write_* ports, with no stall and no backpressure.
REQ-024 out_write_* SHALL be driven directly from stage DEPTH registers; there SHALL be no combinational path from the inputs to out_write_*.
REQ-025 Cancel and IO_Ready SHALL be sampled only at entry; an accepted write SHALL NOT be revoked in flight.
REQ-026 Back-to-back valid writes on consecutive cycles SHALL all emerge, in order, on consecutive cycles.

Reset
REQ-027 While reset=1 at a clock edge: all stages valid=0, addr=IDLE_ADDR, data=0, thread=0, and current_thread=0 after that edge.
REQ-028 Reset asserted mid-flight SHALL discard all in-flight writes; no write issued before reset SHALL appear after it.
REQ-029 hazard SHALL read 0 in the cycle after reset.

Configuration
REQ-030 With macro ADDRESS_WRITE_STAGER_HAZARD_EN defined, hazard SHALL be combinationally 1 when any stage 1..DEPTH holds valid=1, thread==current_thread, and addr==check_addr.
REQ-031 Without ADDRESS_WRITE_STAGER_HAZARD_EN, the hazard port SHALL remain present and be tied to 0, and no comparators SHALL be built.

Structure
REQ-032 A shared package SHALL hold the stage record typedef (valid, addr, data, thread) and the DEPTH legal-range constants.
REQ-033 One sub-module, write_stage_register, SHALL implement a single resettable stage; stages SHALL be instantiated via generate.

Verification
REQ-034 DEPTH=2, THREAD_COUNT=8: entry addr=0x410, data=0x5, IO_Ready=1, Cancel=0 at cycle 0 -> out_write_valid=1, addr=0x410, data=0x5, thread=0 at cycle 2.
REQ-035 Same stimulus with Cancel_previous=1 -> out_write_valid=0 and out_write_addr=IDLE_ADDR at cycle 2.
REQ-036 Reset held for 1 cycle, then 9 free-running cycles -> current_thread sequence 0..7,0.
REQ-037 Valid write at cycle 0, reset at cycle 1 -> out_write_valid=0 at cycles 2 and 3.
REQ-038 HAZARD_EN defined, DEPTH=4, THREAD_COUNT=2: write addr=0x411 from thread 0 at cycle 0, check_addr=0x411 -> hazard=1 at cycles 2 and 4 (thread 0 current), 0 at cycles 1, 3 and 5.
REQ-039 HAZARD_EN undefined, same stimulus -> hazard=0 in all cycles.

Source files
------------

// File: rtl/address_write_stager_pkg.sv
// address_write_stager_pkg: stage record shared by the write stager and its stage register.
// Fields are sized to the widest supported configuration; unused upper bits stay zero.
package address_write_stager_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;

    localparam int STAGE_ADDR_MAX   = 32;
    localparam int STAGE_DATA_MAX   = 128;
    localparam int STAGE_THREAD_MAX = 8;

    typedef struct packed {
        logic                        valid;
        logic [STAGE_ADDR_MAX-1:0]   addr;
        logic [STAGE_DATA_MAX-1:0]   data;
        logic [STAGE_THREAD_MAX-1:0] thread;
    } stage_t;

    function automatic int clamp_depth(input int depth);
        if (depth < DEPTH_MIN) begin
            return DEPTH_MIN;
        end
        if (depth > DEPTH_MAX) begin
            return DEPTH_MAX;
        end
        return depth;
    endfunction

endpackage

// File: rtl/address_write_stager_write_stage_register.sv
// write_stage_register: one resettable retiming stage of the write stager.
// Synchronous active-high reset loads RESET_VALUE.
module write_stage_register
    import address_write_stager_pkg::*;
#(
    parameter stage_t RESET_VALUE = '0
) (
    input  logic   clock,
    input  logic   reset,
    input  stage_t stage_in,
    output stage_t stage_out
);

    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        stage_d = stage_in;
        if (reset) begin
            stage_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clock) begin
        stage_q <= stage_d;
    end

    assign stage_out = stage_q;

endmodule

// File: rtl/address_write_stager.sv
// address_write_stager: fixed-latency retiming of the previous instruction's write.
// Define ADDRESS_WRITE_STAGER_HAZARD_EN to build the in-flight hazard comparators.
module address_write_stager
    import address_write_stager_pkg::*;
#(
    parameter int WRITE_WORD_WIDTH   = 36,
    parameter int WRITE_ADDR_WIDTH   = 12,
    parameter int DEPTH              = 2,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter logic [WRITE_ADDR_WIDTH-1:0] IDLE_ADDR = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WRITE_ADDR_WIDTH-1:0]   in_write_addr,
    input  logic [WRITE_WORD_WIDTH-1:0]   in_write_data,
    input  logic                          IO_Ready_previous,
    input  logic                          Cancel_previous,
    input  logic [WRITE_ADDR_WIDTH-1:0]   check_addr,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
    output logic [WRITE_ADDR_WIDTH-1:0]   out_write_addr,
    output logic [WRITE_WORD_WIDTH-1:0]   out_write_data,
    output logic                          out_write_valid,
    output logic [THREAD_COUNT_WIDTH-1:0] out_write_thread,
    output logic                          hazard
);

    // Out-of-range DEPTH is pulled back into the legal range.
    localparam int STAGES = clamp_depth(DEPTH);

    localparam stage_t RESET_STAGE = '{
        valid:  1'b0,
        addr:   STAGE_ADDR_MAX'(IDLE_ADDR),
        data:   '0,
        thread: '0
    };

    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD =
        THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

    logic [THREAD_COUNT_WIDTH-1:0] thread_d;
    logic [THREAD_COUNT_WIDTH-1:0] thread_q;

    always_comb begin
        thread_d = thread_q + THREAD_COUNT_WIDTH'(1);
        if (thread_q == LAST_THREAD) begin
            thread_d = '0;
        end
        if (reset) begin
            thread_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        thread_q <= thread_d;
    end

    assign current_thread = thread_q;

    stage_t entry;

    // Rejected entries carry the idle address and zero data.
    always_comb begin
        entry        = RESET_STAGE;
        entry.thread = STAGE_THREAD_MAX'(thread_q);
        if (IO_Ready_previous && !Cancel_previous) begin
            entry.valid = 1'b1;
            entry.addr  = STAGE_ADDR_MAX'(in_write_addr);
            entry.data  = STAGE_DATA_MAX'(in_write_data);
        end
    end

    stage_t stage_out [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t stage_in;

        if (k == 0) begin : g_head
            assign stage_in = entry;
        end else begin : g_tail
            assign stage_in = stage_out[k-1];
        end

        write_stage_register #(
            .RESET_VALUE (RESET_STAGE)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .stage_in  (stage_in),
            .stage_out (stage_out[k])
        );
    end

    stage_t tail;

    assign tail             = stage_out[STAGES-1];
    assign out_write_valid  = tail.valid;
    assign out_write_addr   = tail.addr[WRITE_ADDR_WIDTH-1:0];
    assign out_write_data   = tail.data[WRITE_WORD_WIDTH-1:0];
    assign out_write_thread = tail.thread[THREAD_COUNT_WIDTH-1:0];

    logic unused_tail;
    assign unused_tail = ^{tail, check_addr};

`ifdef ADDRESS_WRITE_STAGER_HAZARD_EN
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_out[k].valid
                && stage_out[k].thread == STAGE_THREAD_MAX'(thread_q)
                && stage_out[k].addr == STAGE_ADDR_MAX'(check_addr)) begin
                hazard = 1'b1;
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_address_write_stager.sv
// tb_address_write_stager: scoreboard bench for the write stager.
// Instance a uses defaults; instance b uses DEPTH=4, two threads.
module tb_address_write_stager;

    localparam int A_DEPTH = 2;

`ifdef ADDRESS_WRITE_STAGER_HAZARD_EN
    localparam bit HAZ_ON = 1'b1;
`else
    localparam bit HAZ_ON = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [11:0] a;
        logic [35:0] d;
        logic [2:0]  t;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic        a_rdy = 1'b0;
    logic        a_cxl = 1'b0;
    logic [11:0] a_addr = '0;
    logic [35:0] a_data = '0;
    logic [11:0] a_chk = '0;
    logic [2:0]  a_ct;
    logic [11:0] a_oaddr;
    logic [35:0] a_odata;
    logic        a_ovalid;
    logic [2:0]  a_othread;
    logic        a_hz;

    logic        b_rdy = 1'b0;
    logic        b_cxl = 1'b0;
    logic [11:0] b_addr = '0;
    logic [35:0] b_data = '0;
    logic [11:0] b_chk = '0;
    logic [0:0]  b_ct;
    logic [11:0] b_oaddr;
    logic [35:0] b_odata;
    logic        b_ovalid;
    logic [0:0]  b_othread;
    logic        b_hz;

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q[$];
    logic [2:0] ct_m = '0;
    bit   sb_live = 1'b0;

    always #5 clock = ~clock;

    address_write_stager u_a (
        .clock             (clock),
        .reset             (reset),
        .in_write_addr     (a_addr),
        .in_write_data     (a_data),
        .IO_Ready_previous (a_rdy),
        .Cancel_previous   (a_cxl),
        .check_addr        (a_chk),
        .current_thread    (a_ct),
        .out_write_addr    (a_oaddr),
        .out_write_data    (a_odata),
        .out_write_valid   (a_ovalid),
        .out_write_thread  (a_othread),
        .hazard            (a_hz)
    );

    address_write_stager #(
        .DEPTH              (4),
        .THREAD_COUNT       (2),
        .THREAD_COUNT_WIDTH (1),
        .IDLE_ADDR          (12'hFFF)
    ) u_b (
        .clock             (clock),
        .reset             (reset),
        .in_write_addr     (b_addr),
        .in_write_data     (b_data),
        .IO_Ready_previous (b_rdy),
        .Cancel_previous   (b_cxl),
        .check_addr        (b_chk),
        .current_thread    (b_ct),
        .out_write_addr    (b_oaddr),
        .out_write_data    (b_odata),
        .out_write_valid   (b_ovalid),
        .out_write_thread  (b_othread),
        .hazard            (b_hz)
    );

    task automatic do_cycle(input logic rst, input logic rdy,
                            input logic cxl, input logic [11:0] addr,
                            input logic [35:0] data,
                            input logic [11:0] chk);
        rec_t exp;
        rec_t ent;
        logic hz;
        a_chk = chk;
        #1;
        if (sb_live) begin
            hz = 1'b0;
            if (HAZ_ON) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i].v && exp_q[i].t == ct_m
                        && exp_q[i].a == chk) begin
                        hz = 1'b1;
                    end
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty got=%0d required>0", exp_q.size());
            end else begin
                exp = exp_q.pop_front();
                if ({a_ovalid, a_oaddr, a_odata, a_othread}
                    !== {exp.v, exp.a, exp.d, exp.t}) begin
                    failures++;
                    $display("FAIL out_write got v=%0b a=%h d=%h t=%0d required v=%0b a=%h d=%h t=%0d",
                             a_ovalid, a_oaddr, a_odata, a_othread,
                             exp.v, exp.a, exp.d, exp.t);
                end
            end
            checks++;
            if (a_ct !== ct_m) begin
                failures++;
                $display("FAIL current_thread got=%0d required=%0d", a_ct, ct_m);
            end
            checks++;
            if (a_hz !== hz) begin
                failures++;
                $display("FAIL hazard_a got=%0b required=%0b", a_hz, hz);
            end
        end
        ent.v = rdy & ~cxl;
        ent.a = ent.v ? addr : 12'h000;
        ent.d = ent.v ? data : 36'h0;
        ent.t = ct_m;
        reset = rst;
        a_rdy = rdy;
        a_cxl = cxl;
        a_addr = addr;
        a_data = data;
        @(posedge clock);
        #1;
        reset = 1'b0;
        if (rst) begin
            exp_q.delete();
            repeat (A_DEPTH) exp_q.push_back('{1'b0, 12'h000, 36'h0, 3'd0});
            ct_m = '0;
            sb_live = 1'b1;
        end else begin
            exp_q.push_back(ent);
            ct_m = ct_m + 3'd1;
        end
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, 12'h3C3, 36'hABCDE, 12'h000);
    endtask

    task automatic test_reset();
        do_cycle(1'b1, 1'b1, 1'b0, 12'h555, 36'h7, 12'h000);
        checks++;
        if ({a_ovalid, a_oaddr, a_odata, a_othread, a_ct, a_hz} !== '0) begin
            failures++;
            $display("FAIL reset_a got v=%0b a=%h d=%h t=%0d ct=%0d hz=%0b required all 0",
                     a_ovalid, a_oaddr, a_odata, a_othread, a_ct, a_hz);
        end
        checks++;
        if ({b_ovalid, b_oaddr, b_odata, b_othread, b_ct, b_hz}
            !== {1'b0, 12'hFFF, 36'h0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_b got v=%0b a=%h d=%h t=%0d ct=%0d hz=%0b required idle FFF",
                     b_ovalid, b_oaddr, b_odata, b_othread, b_ct, b_hz);
        end
    endtask

    task automatic test_single_write();
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        do_cycle(1'b0, 1'b1, 1'b0, 12'h410, 36'h5, 12'h000);
        idle();
        checks++;
        if ({a_ovalid, a_oaddr, a_odata, a_othread}
            !== {1'b1, 12'h410, 36'h5, 3'd0}) begin
            failures++;
            $display("FAIL single_write got v=%0b a=%h d=%h t=%0d required v=1 a=410 d=5 t=0",
                     a_ovalid, a_oaddr, a_odata, a_othread);
        end
        idle();
    endtask

    task automatic test_cancel();
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        do_cycle(1'b0, 1'b1, 1'b1, 12'h410, 36'h5, 12'h000);
        idle();
        checks++;
        if ({a_ovalid, a_oaddr, a_odata} !== {1'b0, 12'h000, 36'h0}) begin
            failures++;
            $display("FAIL cancel got v=%0b a=%h d=%h required v=0 a=000 d=0",
                     a_ovalid, a_oaddr, a_odata);
        end
        do_cycle(1'b0, 1'b0, 1'b0, 12'h777, 36'h9, 12'h000);
        idle();
        idle();
    endtask

    task automatic test_thread_wrap();
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (a_ct !== 3'(i % 8)) begin
                failures++;
                $display("FAIL thread_wrap got=%0d required=%0d", a_ct, i % 8);
            end
            idle();
        end
    endtask

    task automatic test_reset_midflight();
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        do_cycle(1'b0, 1'b1, 1'b0, 12'h2A5, 36'h123, 12'h000);
        do_cycle(1'b1, 1'b1, 1'b0, 12'h2A6, 36'h124, 12'h000);
        for (int c = 2; c < 4; c++) begin
            checks++;
            if (a_ovalid !== 1'b0) begin
                failures++;
                $display("FAIL midflight_c%0d got v=%0b required v=0", c, a_ovalid);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] addr;
        logic [11:0] prev;
        logic [35:0] data;
        prev = 12'h000;
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        for (int i = 0; i < 16; i++) begin
            addr = 12'($urandom);
            data = {4'($urandom), 32'($urandom)};
            do_cycle(1'b0, 1'b1, (i % 5) == 3, addr, data, prev);
            prev = addr;
        end
        repeat (A_DEPTH + 1) idle();
    endtask

    task automatic test_hazard();
        logic [5:0] pat;
        logic       exp;
        pat = 6'b010100;
        b_chk = 12'h411;
        do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 36'h0, 12'h000);
        for (int c = 0; c < 6; c++) begin
            b_rdy = (c == 0);
            b_addr = 12'h411;
            b_data = 36'h5;
            #1;
            exp = HAZ_ON ? pat[c] : 1'b0;
            checks++;
            if (b_hz !== exp) begin
                failures++;
                $display("FAIL hazard_b_c%0d got=%0b required=%0b", c, b_hz, exp);
            end
            checks++;
            if (b_ct !== 1'(c % 2)) begin
                failures++;
                $display("FAIL thread_b_c%0d got=%0d required=%0d", c, b_ct, c % 2);
            end
            if (c == 4) begin
                checks++;
                if ({b_ovalid, b_oaddr, b_othread} !== {1'b1, 12'h411, 1'b0}) begin
                    failures++;
                    $display("FAIL out_b got v=%0b a=%h t=%0d required v=1 a=411 t=0",
                             b_ovalid, b_oaddr, b_othread);
                end
            end
            idle();
        end
        b_rdy = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_single_write();
        test_cancel();
        test_thread_wrap();
        test_reset_midflight();
        test_back_to_back();
        test_hazard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
